// File: rtl/vend_pkg.sv
// Shared encodings for the vending transaction path: commands, coins, states, prices.
// Pure declarations; no logic, no latency.
package vend_pkg;

   localparam logic [1:0] CMD_SITEM  = 2'b00;
   localparam logic [1:0] CMD_SMONEY = 2'b01;
   localparam logic [1:0] CMD_CLEAR  = 2'b10;
   localparam logic [1:0] CMD_START  = 2'b11;

   localparam logic [1:0] COIN_1U  = 2'b00;
   localparam logic [1:0] COIN_2U  = 2'b01;
   localparam logic [1:0] COIN_5U  = 2'b10;
   localparam logic [1:0] COIN_20U = 2'b11;

   localparam logic [31:0] DEFAULT_PRICE_TABLE = {8'd25, 8'd20, 8'd15, 8'd10};

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_COLLECT  = 3'd1,
      ST_DISPENSE = 3'd2,
      ST_CHANGE   = 3'd3
   } state_t;

   // Coin face value in 5-cent units.
   function automatic logic [4:0] coin_value(input logic [1:0] code);
      logic [4:0] v;
      case (code)
         COIN_1U: v = 5'd1;
         COIN_2U: v = 5'd2;
         COIN_5U: v = 5'd5;
         default: v = 5'd20;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/vend_txn_ctrl_if.sv
// Command/coin/dispense/payout bundle between main_FSM side and the transaction controller.
// Wires only; master drives the in_* strobes, slave drives the registered out_* signals.
interface vend_txn_ctrl_if #(
   parameter int CREDIT_W = 8
) ();

   logic                in_cmd_valid;
   logic [1:0]          in_cmd;
   logic [1:0]          in_item;
   logic                in_coin_valid;
   logic [1:0]          in_coin;
   logic                in_dispense_done;
   logic                in_change_ready;

   logic [2:0]          out_state;
   logic [CREDIT_W-1:0] out_credit;
   logic [1:0]          out_item;
   logic                out_item_vld;
   logic                out_dispense;
   logic                out_change_valid;
   logic [1:0]          out_change_coin;
   logic                out_coin_reject;
   logic                out_err;

   modport master (
      output in_cmd_valid, in_cmd, in_item, in_coin_valid, in_coin,
             in_dispense_done, in_change_ready,
      input  out_state, out_credit, out_item, out_item_vld, out_dispense,
             out_change_valid, out_change_coin, out_coin_reject, out_err
   );

   modport slave (
      input  in_cmd_valid, in_cmd, in_item, in_coin_valid, in_coin,
             in_dispense_done, in_change_ready,
      output out_state, out_credit, out_item, out_item_vld, out_dispense,
             out_change_valid, out_change_coin, out_coin_reject, out_err
   );

endinterface

// File: rtl/vend_change_sel.sv
// Largest payable coin for a given credit (greedy change-making over 20/5/2/1 units).
// Combinational, zero latency; no handshake.
module vend_change_sel
   import vend_pkg::*;
#(
   parameter int CREDIT_W = 8
) (
   input  logic [CREDIT_W-1:0] credit,
   output logic [1:0]          coin,
   output logic [CREDIT_W-1:0] value
);

   always_comb begin
      if (credit >= CREDIT_W'(coin_value(COIN_20U))) begin
         coin = COIN_20U;
      end else if (credit >= CREDIT_W'(coin_value(COIN_5U))) begin
         coin = COIN_5U;
      end else if (credit >= CREDIT_W'(coin_value(COIN_2U))) begin
         coin = COIN_2U;
      end else begin
         coin = COIN_1U;
      end
      value = CREDIT_W'(coin_value(coin));
   end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction FSM: collects credit, checks price, handshakes dispenser, pays change.
// All outputs registered (1 cycle after the deciding edge); payout stalls while in_change_ready is low.
module vend_txn_ctrl
   import vend_pkg::*;
#(
   parameter int                    CREDIT_W    = 8,
   parameter int                    MAX_CREDIT  = 200,
   parameter logic [4*CREDIT_W-1:0] PRICE_TABLE = DEFAULT_PRICE_TABLE
) (
   input  logic           in_clka,
   input  logic           in_restart_n,
   vend_txn_ctrl_if.slave bus
);

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [1:0]          item_q, item_d;
   logic                item_vld_q, item_vld_d;
   logic                dispense_q, dispense_d;
   logic                chg_vld_q, chg_vld_d;
   logic [1:0]          chg_coin_q, chg_coin_d;
   logic                coin_rej_q, coin_rej_d;
   logic                err_q, err_d;

   logic [CREDIT_W:0]   credit_sum;
   logic                coin_fits;
   logic [CREDIT_W-1:0] price;
   logic                smoney_ok;
   logic [1:0]          sel_coin;
   logic [CREDIT_W-1:0] sel_value;

   // One extra bit so a coin near the ceiling cannot wrap past MAX_CREDIT.
   assign credit_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(bus.in_coin));
   assign coin_fits  = credit_sum <= (CREDIT_W+1)'(MAX_CREDIT);
   assign price      = PRICE_TABLE[int'(item_q)*CREDIT_W +: CREDIT_W];
   assign smoney_ok  = item_vld_q && (credit_q >= price);

   vend_change_sel #(
      .CREDIT_W (CREDIT_W)
   ) u_change_sel (
      .credit (credit_q),
      .coin   (sel_coin),
      .value  (sel_value)
   );

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      item_d     = item_q;
      item_vld_d = item_vld_q;
      dispense_d = dispense_q;
      chg_vld_d  = 1'b0;
      chg_coin_d = 2'b00;
      coin_rej_d = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            coin_rej_d = bus.in_coin_valid;
            if (bus.in_cmd_valid && bus.in_cmd == CMD_START) begin
               state_d = ST_COLLECT;
            end
         end

         ST_COLLECT: begin
            if (bus.in_cmd_valid) begin
               // A command wins the cycle; any coximal coin is bounced.
               coin_rej_d = bus.in_coin_valid;
               case (bus.in_cmd)
                  CMD_SITEM: begin
                     item_d     = bus.in_item;
                     item_vld_d = 1'b1;
                  end
                  CMD_SMONEY: begin
                     if (smoney_ok) begin
                        credit_d   = credit_q - price;
                        dispense_d = 1'b1;
                        state_d    = ST_DISPENSE;
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  CMD_CLEAR: begin
                     item_vld_d = 1'b0;
                     state_d    = ST_CHANGE;
                  end
                  default: ;
               endcase
            end else if (bus.in_coin_valid) begin
               if (coin_fits) begin
                  credit_d = credit_sum[CREDIT_W-1:0];
               end else begin
                  coin_rej_d = 1'b1;
               end
            end
         end

         ST_DISPENSE: begin
            coin_rej_d = bus.in_coin_valid;
            if (bus.in_dispense_done) begin
               dispense_d = 1'b0;
               item_vld_d = 1'b0;
               state_d    = ST_CHANGE;
            end
         end

         ST_CHANGE: begin
            coin_rej_d = bus.in_coin_valid;
            if (credit_q == '0) begin
               state_d = ST_IDLE;
            end else if (bus.in_change_ready) begin
               chg_vld_d  = 1'b1;
               chg_coin_d = sel_coin;
               credit_d   = credit_q - sel_value;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge in_clka) begin
      if (!in_restart_n) begin
         state_q    <= ST_IDLE;
         credit_q   <= '0;
         item_q     <= 2'b00;
         item_vld_q <= 1'b0;
         dispense_q <= 1'b0;
         chg_vld_q  <= 1'b0;
         chg_coin_q <= 2'b00;
         coin_rej_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         item_q     <= item_d;
         item_vld_q <= item_vld_d;
         dispense_q <= dispense_d;
         chg_vld_q  <= chg_vld_d;
         chg_coin_q <= chg_coin_d;
         coin_rej_q <= coin_rej_d;
         err_q      <= err_d;
      end
   end

   assign bus.out_state        = state_q;
   assign bus.out_credit       = credit_q;
   assign bus.out_item         = item_q;
   assign bus.out_item_vld     = item_vld_q;
   assign bus.out_dispense     = dispense_q;
   assign bus.out_change_valid = chg_vld_q;
   assign bus.out_change_coin  = chg_coin_q;
   assign bus.out_coin_reject  = coin_rej_q;
   assign bus.out_err          = err_q;

endmodule

// File: doc/vend_txn_ctrl.md
# vend_txn_ctrl

Transaction controller sitting between `main_FSM` and the vending datapath. It takes the 2-bit command stream from `main_FSM` (START/SITEM/SMONEY/CLEAR), accumulates inserted coin credit, latches the item selection, checks price, and drives the dispenser handshake. It then pays out change one coin per accepted handshake until credit reaches zero. Single clock domain; all outputs are registered.

## Interface
- `CREDIT_W`, 8: credit register width, in 5-cent units.
- `MAX_CREDIT`, 200: highest credit accepted, in units ($10.00).
- `PRICE_TABLE`, {8'd25, 8'd20, 8'd15, 8'd10}: packed 4×`CREDIT_W` prices, in units. Index 0 is the LSB slice.

- `in_clka`  in  1  clock, rising edge.
- `in_restart_n`  in  1  reset; synchronous, active-low.
- `in_cmd_valid`  in  1  one-cycle strobe qualifying `in_cmd`.
- `in_cmd`  in  2  command. SITEM=00, SMONEY=01, CLEAR=10, START=11.
- `in_item`  in  2  item index; sampled with SITEM.
- `in_coin_valid`  in  1  one-cycle coin-insert strobe.
- `in_coin`  in  2  coin code. 00=1u, 01=2u, 10=5u, 11=20u.
- `in_dispense_done`  in  1  dispenser finished.
- `in_change_ready`  in  1  coin hopper can accept a payout this cycle.
- `out_state`  out  3  current state encoding.
- `out_credit`  out  `CREDIT_W`  current credit.
- `out_item`  out  2  latched item.
- `out_item_vld`  out  1  an item is latched.
- `out_dispense`  out  1  dispense request, level.
- `out_change_valid`  out  1  payout coin valid this cycle.
- `out_change_coin`  out  2  payout coin code.
- `out_coin_reject`  out  1  one-cycle pulse: coin refused.
- `out_err`  out  1  one-cycle pulse: SMONEY refused.

## Operation
- States: IDLE=0, COLLECT=1, DISPENSE=2, CHANGE=3.
- **Reset** (`in_restart_n`=0 at an edge): state IDLE; credit 0; item_vld 0; every output 0. Reset mid-transaction discards credit with no payout.
- **IDLE**
  - START → COLLECT.
  - Other commands are ignored.
  - Coins are rejected.
- **COLLECT**
  - Coin with no command in the same cycle: credit += value if the result is ≤ MAX_CREDIT. Otherwise pulse `out_coin_reject` and leave credit unchanged.
  - SITEM: latch `in_item`, set item_vld. Re-selection overwrites the latched item.
  - SMONEY with item_vld and credit ≥ price: credit -= price → DISPENSE. Otherwise pulse `out_err` and stay.
  - CLEAR: clear item_vld → CHANGE (full refund).
  - START: ignored.
  - A coin arriving in the same cycle as any valid command is rejected. The command still executes.
- **DISPENSE**
  - `out_dispense`=1 until `in_dispense_done` is sampled high.
  - Then: `out_dispense`=0, item_vld=0 → CHANGE.
  - Commands are ignored; coins are rejected.
- **CHANGE**
  - When credit = 0 → IDLE.
  - Otherwise, each cycle with `in_change_ready`=1: emit the largest coin ≤ credit, with `out_change_valid`=1, and credit -= its value.
  - When `in_change_ready`=0: `out_change_valid`=0 and credit is held.
  - Commands are ignored; coins are rejected.
- Arithmetic is unsigned `CREDIT_W`. Add in `CREDIT_W`+1 bits before the limit compare. Subtraction never underflows, because of the ≥ checks.

## Timing
- All decisions are made on the edge where inputs are sampled. Results are visible on outputs one cycle later.
- SMONEY accepted at edge k: `out_dispense`=1 and the reduced `out_credit` both appear from k+1.
- `in_dispense_done` at edge k: `out_dispense`=0 and state CHANGE from k+1.
- Payout: with `in_change_ready` held high, one coin per cycle. The IDLE transition occurs on the edge after credit reaches 0.
- Credit 0 on entering CHANGE (e.g. exact payment): exactly one CHANGE cycle with no coin, then IDLE.
- `out_coin_reject` and `out_err` are high for exactly one cycle per offending event.

## Structure
- Package `vend_pkg` holds:
  - command encodings (shared with `main_FSM`);
  - coin codes and a coin-value function;
  - the state enum;
  - the default price table.
- Sub-module `vend_change_sel`: combinational; maps credit to the largest payable coin code and its value.
- The FSM and the credit register live in `vend_txn_ctrl`.

## Test plan
- **Reset:** reset asserted for 2 cycles mid-COLLECT with credit 27 → all outputs 0, state IDLE; no payout.
- **Exact purchase:** START; coins 20u+5u; SITEM item 3 (price 25); SMONEY → `out_dispense` next cycle, credit 0; done → CHANGE → IDLE; no change coins.
- **Overpay:** credit 42, item 0 (price 10), SMONEY, done, `in_change_ready` high → payout 20, 5, 5, 2 on consecutive cycles, then IDLE.
- **Insufficient / no selection:** credit 12, item 2 (price 20), SMONEY → `out_err` pulse, stay COLLECT, credit 12. SMONEY before any SITEM → `out_err`.
- **Overflow and collision:** credit 190 plus coin 20u → `out_coin_reject`, credit 190. A coin in the same cycle as SITEM → reject, item latched.
- **Refund with backpressure:** credit 7, CLEAR, `in_change_ready` toggling 1,0,1 → coins 5 then 2 only on ready cycles, then IDLE.
